// File: rtl/mixer_agc_pkg.sv
// Shared types, widths and helpers for the mixer_agc sequencing and gain-control slice.
package mixer_agc_pkg;

  localparam int AGC_SHIFT_W = 5;
  localparam int AGC_DATA_W  = 24;

  typedef enum logic [1:0] {
    AGC_IDLE,
    AGC_LAUNCH,
    AGC_WAIT_MIX,
    AGC_UPDATE
  } agc_state_t;

  // Magnitude of a signed sample; the most negative code saturates to full-scale positive.
  function automatic logic [AGC_DATA_W-1:0] sat_abs(input logic signed [AGC_DATA_W-1:0] x);
    logic [AGC_DATA_W-1:0] r;
    if (x[AGC_DATA_W-1] && (x[AGC_DATA_W-2:0] == '0)) begin
      r = {1'b0, {(AGC_DATA_W-1){1'b1}}};
    end else if (x[AGC_DATA_W-1]) begin
      r = -x;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mixer_agc_if.sv
// Sample strobe, mixer handshake and audio output bundle; master is the mixer_agc side.
interface mixer_agc_if;

  logic                                    sample_valid_in;
  logic                                    mix_valid_out;
  logic        [mixer_agc_pkg::AGC_SHIFT_W-1:0] shift_out;
  logic signed [mixer_agc_pkg::AGC_DATA_W-1:0]  mixed_in;
  logic                                    mixed_valid_in;
  logic signed [mixer_agc_pkg::AGC_DATA_W-1:0]  audio_out;
  logic                                    audio_valid_out;
  logic                                    overrun_out;
  logic                                    timeout_out;
  logic                                    busy_out;

  modport master (
    input  sample_valid_in, mixed_in, mixed_valid_in,
    output mix_valid_out, shift_out, audio_out, audio_valid_out,
           overrun_out, timeout_out, busy_out
  );

  modport slave (
    output sample_valid_in, mixed_in, mixed_valid_in,
    input  mix_valid_out, shift_out, audio_out, audio_valid_out,
           overrun_out, timeout_out, busy_out
  );

endinterface

// File: rtl/mixer_agc_peak_tracker.sv
// peak_tracker: saturating magnitude of the current sample and a registered running maximum.
module peak_tracker
  import mixer_agc_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [AGC_DATA_W-1:0] sample_i,
  input  logic                         update_i,
  input  logic                         clear_i,
  output logic        [AGC_DATA_W-1:0] mag_o,
  output logic        [AGC_DATA_W-1:0] peak_o
);

  logic [AGC_DATA_W-1:0] peak_q;
  logic [AGC_DATA_W-1:0] peak_d;

  assign mag_o = sat_abs(sample_i);

  always_comb begin
    peak_d = peak_q;
    if (clear_i) begin
      peak_d = '0;
    end else if (update_i && (mag_o > peak_q)) begin
      peak_d = mag_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/mixer_agc.sv
// mixer_agc: launches one mixer pass per sample strobe, forwards the result and steers the mixer shift.
// Optional MIXER_AGC_CLIP_EN: a clipped result raises the shift at once instead of waiting for the window.
module mixer_agc
  import mixer_agc_pkg::*;
#(
  parameter int          WINDOW      = 1024,
  parameter int          SHIFT_INIT  = 16,
  parameter int          SHIFT_MIN   = 0,
  parameter int          SHIFT_MAX   = 31,
  parameter logic [23:0] HIGH_THRESH = 24'h600000,
  parameter logic [23:0] LOW_THRESH  = 24'h100000,
  parameter int          MIX_TIMEOUT = 4096
) (
  input logic         clk_in,
  input logic         rst_in,
  mixer_agc_if.master agc
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam int TMO_W = $clog2(MIX_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]       WIN_LAST   = CNT_W'(WINDOW - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(MIX_TIMEOUT - 1);
  localparam logic [AGC_SHIFT_W-1:0] SHIFT_RST  = AGC_SHIFT_W'(SHIFT_INIT);
  localparam logic [AGC_SHIFT_W-1:0] SHIFT_LO   = AGC_SHIFT_W'(SHIFT_MIN);
  localparam logic [AGC_SHIFT_W-1:0] SHIFT_HI   = AGC_SHIFT_W'(SHIFT_MAX);

  agc_state_t                   state_q;
  logic                         mix_valid_q;
  logic                         audio_valid_q;
  logic                         overrun_q;
  logic                         timeout_q;
  logic                         busy_q;
  logic signed [AGC_DATA_W-1:0] audio_q;
  logic [AGC_SHIFT_W-1:0]       shift_q;
  logic [AGC_SHIFT_W-1:0]       shift_d;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             count_d;
  logic [TMO_W-1:0]             tmo_q;

  logic [AGC_DATA_W-1:0]        mag;
  logic [AGC_DATA_W-1:0]        peak;
  logic [AGC_DATA_W-1:0]        peak_max;
  logic                         window_clear;

  peak_tracker u_peak (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .sample_i (audio_q),
    .update_i (state_q == AGC_UPDATE),
    .clear_i  (window_clear),
    .mag_o    (mag),
    .peak_o   (peak)
  );

  // The decision must include the sample being folded in this cycle.
  assign peak_max = (mag > peak) ? mag : peak;

`ifdef MIXER_AGC_CLIP_EN
  logic clipped;
  // Full-scale either way: every magnitude bit differs from the sign bit.
  assign clipped = &(audio_q[AGC_DATA_W-2:0] ^ {(AGC_DATA_W-1){audio_q[AGC_DATA_W-1]}});
`endif

  always_comb begin
    shift_d      = shift_q;
    count_d      = count_q;
    window_clear = 1'b0;
    if (state_q == AGC_UPDATE) begin
      count_d = count_q + 1'b1;
`ifdef MIXER_AGC_CLIP_EN
      if (clipped && (shift_q < SHIFT_HI)) begin
        shift_d      = shift_q + 1'b1;
        count_d      = '0;
        window_clear = 1'b1;
      end else if (count_q == WIN_LAST) begin
`else
      if (count_q == WIN_LAST) begin
`endif
        if ((peak_max > HIGH_THRESH) && (shift_q < SHIFT_HI)) begin
          shift_d = shift_q + 1'b1;
        end else if ((peak_max < LOW_THRESH) && (shift_q > SHIFT_LO)) begin
          shift_d = shift_q - 1'b1;
        end
        count_d      = '0;
        window_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= AGC_IDLE;
      mix_valid_q   <= 1'b0;
      audio_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      audio_q       <= '0;
      shift_q       <= SHIFT_RST;
      count_q       <= '0;
      tmo_q         <= '0;
    end else begin
      mix_valid_q   <= 1'b0;
      audio_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      // Strobes arriving while a pass is in flight are reported and dropped.
      overrun_q     <= agc.sample_valid_in && (state_q != AGC_IDLE);
      unique case (state_q)
        AGC_IDLE: begin
          if (agc.sample_valid_in) begin
            state_q     <= AGC_LAUNCH;
            mix_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        AGC_LAUNCH: begin
          tmo_q   <= '0;
          state_q <= AGC_WAIT_MIX;
        end
        AGC_WAIT_MIX: begin
          tmo_q <= tmo_q + 1'b1;
          if (agc.mixed_valid_in) begin
            audio_q       <= agc.mixed_in;
            audio_valid_q <= 1'b1;
            state_q       <= AGC_UPDATE;
          end else if (tmo_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= AGC_IDLE;
          end
        end
        AGC_UPDATE: begin
          shift_q <= shift_d;
          count_q <= count_d;
          busy_q  <= 1'b0;
          state_q <= AGC_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= AGC_IDLE;
        end
      endcase
    end
  end

  assign agc.mix_valid_out   = mix_valid_q;
  assign agc.shift_out       = shift_q;
  assign agc.audio_out       = audio_q;
  assign agc.audio_valid_out = audio_valid_q;
  assign agc.overrun_out     = overrun_q;
  assign agc.timeout_out     = timeout_q;
  assign agc.busy_out        = busy_q;

endmodule

// File: doc/mixer_agc.md
# mixer_agc

Sequencing and gain-control front end for the vocoder mixer. Each incoming audio sample strobe launches one mixer pass and waits for its result. The block forwards the mixed sample downstream and, once per window of samples, adjusts the mixer's output shift so that the peak output level stays between two thresholds. It sits between the filter-bank sample strobe and the mixer, and owns the mixer's `valid_in` and `shift` inputs.

## Interface
Parameters:
- `WINDOW`, 1024: completed mixes per gain decision; ≥2.
- `SHIFT_INIT`, 16: shift after reset.
- `SHIFT_MIN`, 0: lowest allowed shift.
- `SHIFT_MAX`, 31: highest allowed shift. Requires SHIFT_MIN ≤ SHIFT_INIT ≤ SHIFT_MAX ≤ 31.
- `HIGH_THRESH`, 24'h600000: window peak above this raises the shift.
- `LOW_THRESH`, 24'h100000: window peak below this lowers the shift. Requires LOW_THRESH < HIGH_THRESH.
- `MIX_TIMEOUT`, 4096: maximum cycles spent waiting for the mixer.

Ports:
- `clk_in`  in  1: system clock; single clock domain.
- `rst_in`  in  1: synchronous, active-high reset.
- `sample_valid_in`  in  1: new filter-bank channels are ready.
- `mix_valid_out`  out  1: one-cycle launch pulse to the mixer's `valid_in`.
- `shift_out`  out  5: drives the mixer's `shift`.
- `mixed_in`  in  24 signed: mixer result.
- `mixed_valid_in`  in  1: mixer result strobe.
- `audio_out`  out  24 signed: forwarded mixed sample.
- `audio_valid_out`  out  1: one-cycle pulse, `audio_out` valid.
- `overrun_out`  out  1: one-cycle pulse, sample strobe dropped.
- `timeout_out`  out  1: one-cycle pulse, mixer did not answer.
- `busy_out`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_MIX, UPDATE.
- **IDLE:**
  - On `sample_valid_in`, go to LAUNCH.
- **LAUNCH:**
  - Assert `mix_valid_out` for this cycle only.
  - Clear the timeout counter.
  - Go to WAIT_MIX.
- **WAIT_MIX:**
  - Increment the timeout counter every cycle.
  - On `mixed_valid_in`, register `mixed_in` into `audio_out`, pulse `audio_valid_out` on the next cycle, and go to UPDATE.
  - If the counter reaches MIX_TIMEOUT−1 without `mixed_valid_in`, pulse `timeout_out` and return to IDLE. The window count and peak are left untouched.
  - `mixed_valid_in` takes priority over timeout when both occur in the same cycle.
- **UPDATE:**
  - `mag = |audio_out|`. The value −2^23 saturates to 2^23−1.
  - `peak <= max(peak, mag)`; `count <= count+1`.
  - If `count == WINDOW−1`, decide using `p = max(peak, mag)`:
    - p > HIGH_THRESH and shift < SHIFT_MAX: shift+1.
    - Otherwise, p < LOW_THRESH and shift > SHIFT_MIN: shift−1.
    - Otherwise: hold.
    - Then clear `peak` and `count`.
  - Return to IDLE.
- `shift_out` changes only in UPDATE. It is therefore stable from LAUNCH until the mixer result is returned.
- `sample_valid_in` in any state other than IDLE pulses `overrun_out` in the following cycle and the strobe is dropped. It is not queued.
- Stray `mixed_valid_in` outside WAIT_MIX is ignored.
- Reset mid-operation abandons the pass. No `audio_valid_out` follows.

## Timing
- Reset values:
  - `shift_out` = SHIFT_INIT.
  - `audio_out`, `mix_valid_out`, `audio_valid_out`, `overrun_out`, `timeout_out`, `busy_out` = 0.
  - `peak` and `count` = 0; state = IDLE.
- `sample_valid_in` at cycle t (in IDLE) produces `mix_valid_out` at t+1.
- `mixed_valid_in` at cycle m produces `audio_valid_out` at m+1, and the state is UPDATE at m+1.
- The new `shift_out` is visible at m+2, and the block is back in IDLE at m+2.
- Minimum sample spacing is therefore mixer latency + 3 cycles.
- All outputs are registered.

## Configuration
- Macro: `MIXER_AGC_CLIP_EN`.
- **Defined:** in UPDATE, if `audio_out` equals 24'h7FFFFF or 24'h800000 and shift < SHIFT_MAX:
  - Shift increments immediately, regardless of `count`.
  - `peak` and `count` are cleared.
  - This takes precedence over the window decision.
- **Undefined:** only window-based decisions are made. Clipped samples are treated as magnitude 2^23−1.

## Structure
- Add `agc_state_t` (IDLE, LAUNCH, WAIT_MIX, UPDATE) to the shared `constants` package.
- Add `AGC_SHIFT_W = 5` to the shared `constants` package.
- Sub-module `peak_tracker`: saturating absolute value, running max, clear input. Purely registered peak, with a `mag` output combinational from its input.

## Test plan
- **Launch/forward:** reset, then `sample_valid_in` at t0 → `mix_valid_out` at t0+1. Model returns 24'h001234 at m → `audio_out` = 24'h001234 with `audio_valid_out` at m+1.
- **Gain up:** WINDOW=4, outputs {0x100, 0x700000, 0x10, 0x20}, SHIFT_INIT=16 → `shift_out` = 17 at m4+2 and stays 16 before that.
- **Gain down/limit:** WINDOW=4, all outputs 0x000100, SHIFT_MIN=15, SHIFT_INIT=16 → 15 after window 1, still 15 after window 2.
- **Overrun:** `sample_valid_in` during WAIT_MIX → `overrun_out` pulse one cycle later; exactly one `mix_valid_out` is issued in total.
- **Timeout:** MIX_TIMEOUT=8, model never answers → `timeout_out` pulse, return to IDLE, `count` unchanged. The next sample launches normally.
- **Clip (MIXER_AGC_CLIP_EN):** output 24'h800000 with count=1 → shift+1 at m+2 and `count` reset to 0. Without the macro, shift is unchanged.
